boton_evento: RTL and testbench

- Consumer end of the button chain: takes one debounced button level (1 = pressed) and turns each press into single-cycle events.
- Events are a short press (released before LONG_COUNT cycles) or a long press (held LONG_COUNT cycles), plus an optional auto-repeat.
- Feeds the mode/state machine, which acts only on these one-cycle pulses and never on raw levels.

---
 rtl/boton_pkg.sv | 18 +
 rtl/boton_evento_if.sv | 30 +++
 rtl/boton_evento.sv | 129 ++++++++++++
 tb/tb_boton_evento.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/boton_pkg.sv
// Shared types and timing defaults for the button event chain.
// Optional feature macro used by this block: BOTON_REPEAT_EN.
package boton_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } state_t;

   localparam int unsigned CLK_HZ    = 50000000;
   localparam int unsigned LONG_MS   = 1000;
   localparam int unsigned REPEAT_MS = 250;

   localparam int unsigned DEF_LONG_COUNT   = (CLK_HZ / 1000) * LONG_MS;
   localparam int unsigned DEF_REPEAT_COUNT = (CLK_HZ / 1000) * REPEAT_MS;

endpackage

// File: rtl/boton_evento_if.sv
// Button level in, one-cycle event pulses and held level out, plus the FSM state for observation.
// Signals are plain levels/pulses sampled on clk; there is no valid/ready handshake on this link.
interface boton_evento_if;
   import boton_pkg::*;

   logic   boton_in;
   logic   pulso_corto;
   logic   pulso_largo;
   logic   pulso_repetir;
   logic   sostenido;
   state_t estado;

   modport slave (
      input  boton_in,
      output pulso_corto,
      output pulso_largo,
      output pulso_repetir,
      output sostenido,
      output estado
   );

   modport master (
      output boton_in,
      input  pulso_corto,
      input  pulso_largo,
      input  pulso_repetir,
      input  sostenido,
      input  estado
   );
endinterface

// File: rtl/boton_evento.sv
// Turns a debounced button level into short/long (and optional repeat) one-cycle events.
// Auto-repeat pulses are built only when BOTON_REPEAT_EN is defined.
module boton_evento
   import boton_pkg::*;
#(
   parameter int unsigned LONG_COUNT   = DEF_LONG_COUNT,
   parameter int unsigned REPEAT_COUNT = DEF_REPEAT_COUNT
) (
   input  logic           clk,
   input  logic           reset,
   boton_evento_if.slave  bus
);

   localparam int unsigned CNT_MAX = (LONG_COUNT > REPEAT_COUNT) ? LONG_COUNT : REPEAT_COUNT;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] LONG_M1 = CW'(LONG_COUNT - 1);
`ifdef BOTON_REPEAT_EN
   localparam logic [CW-1:0] REP_M1  = CW'(REPEAT_COUNT - 1);
`endif

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [CW-1:0] w_cnt_inc;
   logic          r_prev;
   logic          w_rise;

   logic          r_corto, w_corto_d;
   logic          r_largo, w_largo_d;
   logic          r_sost,  w_sost_d;

   // Saturating increment: the counter never wraps back to zero.
   assign w_cnt_inc = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);
   assign w_rise    = bus.boton_in & ~r_prev;

   // prev resets to 1 so a button held through reset never looks like a new press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_prev  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_prev  <= bus.boton_in;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_rise) begin
               w_state_nxt = PRESSED;
               w_cnt_nxt   = CW'(1);
            end
         end
         PRESSED: begin
            // Release is tested first so a release on the threshold cycle stays a short press.
            if (!bus.boton_in) begin
               w_state_nxt = IDLE;
            end else if (r_cnt == LONG_M1) begin
               w_state_nxt = HELD;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = w_cnt_inc;
            end
         end
         HELD: begin
            if (!bus.boton_in) begin
               w_state_nxt = IDLE;
            end
`ifdef BOTON_REPEAT_EN
            else if (r_cnt == REP_M1) begin
               w_cnt_nxt = '0;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
`endif
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      w_corto_d = (r_state == PRESSED) && !bus.boton_in;
      w_largo_d = (r_state == PRESSED) && bus.boton_in && (r_cnt == LONG_M1);
      w_sost_d  = (w_state_nxt == HELD);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_corto <= 1'b0;
         r_largo <= 1'b0;
         r_sost  <= 1'b0;
      end else begin
         r_corto <= w_corto_d;
         r_largo <= w_largo_d;
         r_sost  <= w_sost_d;
      end
   end

`ifdef BOTON_REPEAT_EN
   logic r_rep;
   logic w_rep_d;

   assign w_rep_d = (r_state == HELD) && bus.boton_in && (r_cnt == REP_M1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_rep <= 1'b0;
      else       r_rep <= w_rep_d;
   end

   assign bus.pulso_repetir = r_rep;
`else
   assign bus.pulso_repetir = 1'b0;
`endif

   assign bus.pulso_corto = r_corto;
   assign bus.pulso_largo = r_largo;
   assign bus.sostenido   = r_sost;
   assign bus.estado      = r_state;

endmodule

// File: tb/tb_boton_evento.sv
// Directed bench for boton_evento with LONG_COUNT=8, REPEAT_COUNT=4.
// Output vectors are {pulso_corto, pulso_largo, pulso_repetir, sostenido}.
module tb_boton_evento;
   import boton_pkg::*;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   boton_evento_if bus_if ();

   boton_evento #(
      .LONG_COUNT   (8),
      .REPEAT_COUNT (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] outs();
      return {bus_if.pulso_corto, bus_if.pulso_largo, bus_if.pulso_repetir, bus_if.sostenido};
   endfunction

   task automatic chk_outs(input string tag, input logic [3:0] exp);
      logic [3:0] obs;
      obs = outs();
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input state_t exp);
      state_t obs;
      obs = bus_if.estado;
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   // Drive one sample, let one edge take it, then check what that edge registered.
   task automatic step(input logic b, input logic [3:0] exp, input string tag);
      bus_if.boton_in = b;
      @(posedge clk);
      #1;
      chk_outs(tag, exp);
   endtask

   initial begin
      logic [3:0] rep_v;
      total = 0;
      bad   = 0;
      bus_if.boton_in = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk_outs("reset_outs", 4'b0000);
      chk_state("reset_state", IDLE);

      // Short press N=3
      step(1'b0, 4'b0000, "idle");
      for (int i = 0; i < 3; i++) step(1'b1, 4'b0000, "n3_hold");
      chk_state("n3_pressed", PRESSED);
      step(1'b0, 4'b1000, "n3_corto");
      step(1'b0, 4'b0000, "n3_after");
      chk_state("n3_idle", IDLE);

      // N=7 is still short
      for (int i = 0; i < 7; i++) step(1'b1, 4'b0000, "n7_hold");
      step(1'b0, 4'b1000, "n7_corto");
      step(1'b0, 4'b0000, "n7_after");

      // N=8 is long; held 19 samples then released
      for (int i = 0; i < 7; i++) step(1'b1, 4'b0000, "n8_pre");
      step(1'b1, 4'b0101, "n8_largo");
      chk_state("n8_held", HELD);
      for (int n = 9; n <= 19; n++) begin
`ifdef BOTON_REPEAT_EN
         rep_v = (n == 12 || n == 16) ? 4'b0011 : 4'b0001;
`else
         rep_v = 4'b0001;
`endif
         step(1'b1, rep_v, "held_rep");
      end
      step(1'b0, 4'b0000, "held_release");
      step(1'b0, 4'b0000, "held_after");
      chk_state("held_idle", IDLE);

      // Button held across reset release produces nothing
      bus_if.boton_in = 1'b1;
      reset = 1'b1;
      @(posedge clk);
      #3;
      reset = 1'b0;
      for (int i = 0; i < 20; i++) step(1'b1, 4'b0000, "thru_reset_hold");
      chk_state("thru_reset_idle", IDLE);
      step(1'b0, 4'b0000, "thru_reset_rel");
      step(1'b0, 4'b0000, "thru_reset_rel2");
      step(1'b1, 4'b0000, "n2_a");
      step(1'b1, 4'b0000, "n2_b");
      step(1'b0, 4'b1000, "n2_corto");
      step(1'b0, 4'b0000, "n2_after");

      // Asynchronous reset mid-PRESSED (counter=5)
      for (int i = 0; i < 5; i++) step(1'b1, 4'b0000, "mid_hold");
      chk_state("mid_pressed", PRESSED);
      #2;
      reset = 1'b1;
      #1;
      chk_outs("mid_async_outs", 4'b0000);
      chk_state("mid_async_state", IDLE);
      #2;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b1, 4'b0000, "mid_post_hold");
      step(1'b0, 4'b0000, "mid_post_rel");
      step(1'b0, 4'b0000, "mid_post_rel2");
      for (int i = 0; i < 3; i++) step(1'b1, 4'b0000, "mid_n3_hold");
      step(1'b0, 4'b1000, "mid_n3_corto");
      step(1'b0, 4'b0000, "mid_n3_after");

      // Asynchronous reset while HELD clears sostenido without an edge
      for (int i = 0; i < 8; i++) step(1'b1, (i == 7) ? 4'b0101 : 4'b0000, "hr_hold");
      step(1'b1, 4'b0001, "hr_sost");
      #2;
      reset = 1'b1;
      #1;
      chk_outs("hr_async_outs", 4'b0000);
      chk_state("hr_async_state", IDLE);
      #2;
      reset = 1'b0;
      step(1'b0, 4'b0000, "hr_rel");
      step(1'b0, 4'b0000, "hr_rel2");

      // Back-to-back presses with a one-cycle gap
      step(1'b1, 4'b0000, "b2b_1");
      step(1'b1, 4'b0000, "b2b_2");
      step(1'b0, 4'b1000, "b2b_corto1");
      step(1'b1, 4'b0000, "b2b_4");
      step(1'b1, 4'b0000, "b2b_5");
      step(1'b0, 4'b1000, "b2b_corto2");
      step(1'b0, 4'b0000, "b2b_after");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
